// File: rtl/fractal_pkg.sv
// Shared types and default widths for the escape-time engine.
// Complex operand bundle, FSM states, fixed-point format.
package fractal_pkg;

  localparam int DW         = 18;
  localparam int FRAC       = 13;
  localparam int MAX_ITER_D = 255;
  localparam int IW_D       = $clog2(MAX_ITER_D + 1);

  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } cplx_t;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    DONE
  } fsm_e;

endpackage

// File: rtl/fractal_iter_engine_if.sv
// Pixel request / result handshake bundle.
// master = pixel source + result sink, slave = engine.
interface fractal_iter_engine_if #(
  parameter int DW = fractal_pkg::DW,
  parameter int IW = fractal_pkg::IW_D
);

  logic                 in_valid;
  logic                 in_ready;
  logic [11:0]          in_x;
  logic [11:0]          in_y;
  logic                 in_julia;
  logic signed [DW-1:0] c_re;
  logic signed [DW-1:0] c_im;
  logic [IW-1:0]        max_iter;
  logic [2*DW-1:0]      thres;
  logic                 out_valid;
  logic                 out_ready;
  logic [IW-1:0]        out_count;
  logic                 out_escaped;

  modport master (
    output in_valid, in_x, in_y, in_julia,
    output c_re, c_im, max_iter, thres,
    output out_ready,
    input  in_ready, out_valid,
    input  out_count, out_escaped
  );

  modport slave (
    input  in_valid, in_x, in_y, in_julia,
    input  c_re, c_im, max_iter, thres,
    input  out_ready,
    output in_ready, out_valid,
    output out_count, out_escaped
  );

endinterface

// File: rtl/fractal_cplx_sq.sv
// Complex square in fixed point plus full-precision |z|^2.
// Products keep all bits; scaled results wrap to DW.
module fractal_cplx_sq
  import fractal_pkg::*;
(
  input  cplx_t         z_i,
  output cplx_t         sq_o,
  output logic [2*DW:0] mag_o
);

  logic signed [2*DW-1:0] rr;
  logic signed [2*DW-1:0] ii;
  logic signed [2*DW-1:0] ri;
  logic signed [2*DW:0]   d;
  logic signed [2*DW:0]   t;

  // Squares, cross term, and the scaled real/imag parts
  always_comb begin
    rr = $signed(z_i.re) * $signed(z_i.re);
    ii = $signed(z_i.im) * $signed(z_i.im);
    ri = $signed(z_i.re) * $signed(z_i.im);
    d  = {rr[2*DW-1], rr} - {ii[2*DW-1], ii};
    t  = {ri, 1'b0};
    sq_o.re = DW'(d >>> FRAC);
    sq_o.im = DW'(t >>> FRAC);
    mag_o   = {1'b0, rr} + {1'b0, ii};
  end

endmodule

// File: rtl/fractal_iter_engine.sv
// Escape-time engine: one pixel at a time, z <= z^2 + c.
// Julia (z0=pixel) or Mandelbrot (c=pixel), valid/ready both sides.
module fractal_iter_engine
  import fractal_pkg::*;
#(
  parameter int MAX_ITER  = MAX_ITER_D,
  parameter int X_OFF     = 512,
  parameter int Y_OFF     = 384,
  parameter int PIX_SHIFT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  output logic busy,
  fractal_iter_engine_if.slave bus
);

  localparam int IW = $clog2(MAX_ITER + 1);
  localparam int SH = FRAC - PIX_SHIFT;

  fsm_e            state_q;
  cplx_t           z_q;
  cplx_t           c_q;
  logic [IW-1:0]   n_q;
  logic [IW-1:0]   lim_q;
  logic [2*DW-1:0] thres_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic [IW-1:0]   out_count_q;
  logic            out_esc_q;
  logic            busy_q;

  logic signed [12:0] dx;
  logic signed [12:0] dy;
  cplx_t              px;
  logic [IW-1:0]      lim_d;
  cplx_t              sq;
  logic [2*DW:0]      mag;
  cplx_t              z_d;
  logic               esc;

  fractal_cplx_sq u_sq (
    .z_i   (z_q),
    .sq_o  (sq),
    .mag_o (mag)
  );

  // Pixel mapping, limit clipping, next iterate, escape test
  always_comb begin
    dx    = {1'b0, bus.in_x} - 13'(X_OFF);
    dy    = {1'b0, bus.in_y} - 13'(Y_OFF);
    px.re = {{(DW-13){dx[12]}}, dx} <<< SH;
    px.im = {{(DW-13){dy[12]}}, dy} <<< SH;
    lim_d = (bus.max_iter > IW'(MAX_ITER))
          ? IW'(MAX_ITER) : bus.max_iter;
    z_d.re = sq.re + c_q.re;
    z_d.im = sq.im + c_q.im;
    esc    = (mag >= {1'b0, thres_q});
  end

  // Control FSM with datapath registers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      z_q         <= '0;
      c_q         <= '0;
      n_q         <= '0;
      lim_q       <= '0;
      thres_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_count_q <= '0;
      out_esc_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else if (flush) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            z_q        <= bus.in_julia ? px : '0;
            c_q.re     <= bus.in_julia ? bus.c_re : px.re;
            c_q.im     <= bus.in_julia ? bus.c_im : px.im;
            n_q        <= '0;
            lim_q      <= lim_d;
            thres_q    <= bus.thres;
            state_q    <= ITER;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        ITER: begin
          if (esc || n_q == lim_q) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            out_count_q <= n_q;
            out_esc_q   <= esc;
          end else begin
            z_q <= z_d;
            n_q <= n_q + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_count   = out_count_q;
  assign bus.out_escaped = out_esc_q;
  assign busy            = busy_q;

endmodule
